// File: rtl/spike_scan_filter.sv
// Tick-matching spike scan filter.
// Once per tick it reads the spike-time memory word by word. Each TICK_W lane is compared
// with the tick value latched at start, and the index of every matching neuron is pushed
// into the event FIFO. The FIFO full flag stalls the push without losing any match.
module spike_scan_filter #(
    parameter int N      = 256,
    parameter int TICK_W = 8,
    parameter int WORD_W = 32,
    parameter int RD_LAT = 1,
    localparam int EPW    = WORD_W / TICK_W,
    localparam int NWORDS = N / EPW,
    localparam int AW     = $clog2(NWORDS),
    localparam int IW     = $clog2(N)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start_i,
    input  logic [TICK_W-1:0] tick_i,
    input  logic              next_tick_i,
    output logic              mem_rd_en_o,
    output logic [AW-1:0]     mem_addr_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic              fifo_w_en_o,
    output logic [IW-1:0]     fifo_w_data_o,
    input  logic              fifo_full_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic [IW:0]       match_cnt_o
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SCAN, DONE} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     word_idx;
    logic [EPW-1:0]    mask;
    logic [EPW-1:0]    hit;
    logic [TICK_W-1:0] tick_q;
    logic [2:0]        wcnt;
    logic [IW:0]       match_cnt;
    logic [IW-1:0]     lane_sel;
    logic              busy, abort, push, last_wait, last_word;

    // One comparator per lane against the latched tick
    for (genvar l = 0; l < EPW; l++) begin : g_lane
        assign hit[l] = (mem_rdata_i[l*TICK_W +: TICK_W] == tick_q);
    end

    assign busy      = (state == READ) || (state == WAIT) || (state == SCAN);
    assign abort     = busy && next_tick_i;
    assign last_wait = (state == WAIT) && (wcnt == 3'(RD_LAT - 1));
    assign last_word = (word_idx == AW'(NWORDS - 1));
    // A tick boundary wins over a pending push so nothing is written in the abort cycle
    assign push      = (state == SCAN) && (mask != '0) && !fifo_full_i && !next_tick_i;

    // Priority encoder: lowest pending lane is served first
    always_comb begin
        lane_sel = '0;
        for (int l = EPW - 1; l >= 0; l--)
            if (mask[l]) lane_sel = IW'(l);
    end

    // Next-state logic; abort from any busy state overrides the normal flow
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_i) state_nx = READ;
            READ: state_nx = WAIT;
            WAIT: if (last_wait) state_nx = SCAN;
            SCAN: if (mask == '0) state_nx = last_word ? DONE : READ;
            DONE: if (next_tick_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // State register plus datapath registers (tick latch, word pointer, mask, counters)
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= IDLE;
            word_idx  <= '0;
            mask      <= '0;
            tick_q    <= '0;
            wcnt      <= '0;
            match_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start_i) begin
                    tick_q    <= tick_i;
                    word_idx  <= '0;
                    match_cnt <= '0;
                end
                READ: wcnt <= '0;
                WAIT: if (!abort) begin
                    if (last_wait) mask <= hit;
                    else           wcnt <= wcnt + 3'd1;
                end
                SCAN: begin
                    if (push) begin
                        mask <= mask & (mask - EPW'(1));
                        if (match_cnt < (IW+1)'(N)) match_cnt <= match_cnt + (IW+1)'(1);
                    end else if (mask == '0 && !abort && !last_word) begin
                        word_idx <= word_idx + AW'(1);
                    end
                end
                default: ;
            endcase
            if (abort) mask <= '0;
        end
    end

    assign mem_rd_en_o   = (state == READ);
    assign mem_addr_o    = word_idx;
    assign fifo_w_en_o   = push;
    assign fifo_w_data_o = IW'(word_idx) * IW'(EPW) + lane_sel;
    assign busy_o        = busy;
    assign done_o        = (state == DONE);
    assign overrun_o     = abort;
    assign match_cnt_o   = match_cnt;

endmodule

// File: tb/tb_spike_scan_filter.sv
// Bench for spike_scan_filter: a default-parameter instance (A) for most scenarios and a
// narrow, slow-memory instance (B) for the read-latency scenario. Expected event streams
// come from walking the memory image lane by lane.
module tb_spike_scan_filter;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    // instance A: N=256 TICK_W=8 WORD_W=32 RD_LAT=1
    logic        a_start, a_next, a_rd_en, a_wen, a_full, a_busy, a_done, a_ovr;
    logic [7:0]  a_tick, a_wdata;
    logic [5:0]  a_addr;
    logic [31:0] a_rdata;
    logic [8:0]  a_cnt;

    // instance B: N=64 TICK_W=4 WORD_W=16 RD_LAT=3
    logic        b_start, b_next, b_rd_en, b_wen, b_full, b_busy, b_done, b_ovr;
    logic [3:0]  b_tick, b_addr;
    logic [5:0]  b_wdata;
    logic [15:0] b_rdata;
    logic [6:0]  b_cnt;

    spike_scan_filter dut_a (
        .CLK(CLK), .RSTN(RSTN), .start_i(a_start), .tick_i(a_tick), .next_tick_i(a_next),
        .mem_rd_en_o(a_rd_en), .mem_addr_o(a_addr), .mem_rdata_i(a_rdata),
        .fifo_w_en_o(a_wen), .fifo_w_data_o(a_wdata), .fifo_full_i(a_full),
        .busy_o(a_busy), .done_o(a_done), .overrun_o(a_ovr), .match_cnt_o(a_cnt)
    );

    spike_scan_filter #(.N(64), .TICK_W(4), .WORD_W(16), .RD_LAT(3)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .start_i(b_start), .tick_i(b_tick), .next_tick_i(b_next),
        .mem_rd_en_o(b_rd_en), .mem_addr_o(b_addr), .mem_rdata_i(b_rdata),
        .fifo_w_en_o(b_wen), .fifo_w_data_o(b_wdata), .fifo_full_i(b_full),
        .busy_o(b_busy), .done_o(b_done), .overrun_o(b_ovr), .match_cnt_o(b_cnt)
    );

    // Memory models. When no read is due, the bus carries a word whose every lane equals
    // the current tick, so sampling on the wrong cycle shows up as spurious events.
    logic [31:0] mem_a [64];
    logic [15:0] mem_b [16];
    logic [31:0] pipe_a;
    logic [15:0] pipe_b [3];

    always @(posedge CLK) pipe_a <= a_rd_en ? mem_a[a_addr] : {4{a_tick}};
    assign a_rdata = pipe_a;

    always @(posedge CLK) begin
        pipe_b[0] <= b_rd_en ? mem_b[b_addr] : {4{b_tick}};
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_rdata = pipe_b[2];

    int checks = 0;
    int failures = 0;
    int wq[$];
    int wc[$];
    int exp_q[$];
    int done_cyc;

    task automatic fill_a(input logic [31:0] v);
        for (int w = 0; w < 64; w++) mem_a[w] = v;
    endtask

    // Run one full scan on A, collect FIFO writes and score them against the memory image.
    // mode 0: FIFO never full; 1: random full; 2: full for cycles 2..4 after READ entry.
    task automatic run_a(input string name, input logic [7:0] t, input int mode);
        exp_q.delete();
        for (int w = 0; w < 64; w++)
            for (int l = 0; l < 4; l++)
                if (mem_a[w][l*8 +: 8] == t) exp_q.push_back(w * 4 + l);
        wq.delete();
        wc.delete();
        done_cyc = -1;
        a_tick = t;
        a_start = 1'b1;
        @(posedge CLK); #1;
        a_start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_full = (mode == 1) ? ($urandom % 3 == 0) : (mode == 2) ? (cyc >= 2 && cyc <= 4) : 1'b0;
            #1;
            if (a_wen) begin
                checks++;
                if (a_full) begin
                    failures++;
                    $display("FAIL %s write_while_full: w_en=1 full=1 at cycle %0d (required no write)", name, cyc);
                end
                wq.push_back(int'(a_wdata));
                wc.push_back(cyc);
            end
            if (a_done) begin done_cyc = cyc; break; end
            @(posedge CLK); #1;
        end
        a_full = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s done_timeout: done_o never rose within 3000 cycles", name);
        end
        checks++;
        if (wq.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d required %0d", name, wq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wq.size(); i++) begin
                checks++;
                if (wq[i] != exp_q[i]) begin
                    failures++;
                    $display("FAIL %s write[%0d]: got %0d required %0d", name, i, wq[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (a_cnt !== 9'(exp_q.size())) begin
            failures++;
            $display("FAIL %s match_cnt: got %0d required %0d", name, a_cnt, exp_q.size());
        end
        if (mode == 0) begin
            checks++;
            if (done_cyc != 192 + exp_q.size()) begin
                failures++;
                $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, 192 + exp_q.size());
            end
        end
        // tick boundary releases DONE without flagging an overrun
        a_next = 1'b1;
        #1;
        checks++;
        if (a_ovr !== 1'b0 || a_done !== 1'b1) begin
            failures++;
            $display("FAIL %s release: overrun=%b done=%b required overrun=0 done=1", name, a_ovr, a_done);
        end
        @(posedge CLK); #1;
        a_next = 1'b0;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_release: done=%b busy=%b required 0 0", name, a_done, a_busy);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({a_busy, a_done, a_ovr, a_wen, a_rd_en} !== 5'b0 || a_cnt !== 9'd0 || a_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_a: busy=%b done=%b ovr=%b wen=%b rd=%b cnt=%0d addr=%0d required all 0",
                     a_busy, a_done, a_ovr, a_wen, a_rd_en, a_cnt, a_addr);
        end
        checks++;
        if ({b_busy, b_done, b_ovr, b_wen, b_rd_en} !== 5'b0 || b_cnt !== 7'd0) begin
            failures++;
            $display("FAIL reset_b: busy=%b done=%b ovr=%b wen=%b rd=%b cnt=%0d required all 0",
                     b_busy, b_done, b_ovr, b_wen, b_rd_en, b_cnt);
        end
        RSTN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_empty();
        fill_a(32'hFFFF_FFFF);
        run_a("empty", 8'h05, 0);
    endtask

    task automatic test_two_match();
        fill_a(32'hFFFF_FFFF);
        mem_a[3] = 32'h0500_0500;
        run_a("two_match", 8'h05, 0);
        checks++;
        if (wc.size() != 2 || wc[0] != 11 || wc[1] != 12) begin
            failures++;
            $display("FAIL two_match_timing: write cycles %p required '{11, 12}", wc);
        end
    endtask

    task automatic test_backpressure();
        fill_a(32'hFFFF_FFFF);
        mem_a[0] = 32'h0505_0505;
        run_a("backpressure", 8'h05, 2);
        checks++;
        if (wc.size() != 4 || wc[0] != 5 || wc[3] != 8) begin
            failures++;
            $display("FAIL backpressure_timing: write cycles %p required '{5, 6, 7, 8}", wc);
        end
        checks++;
        if (done_cyc != 199) begin
            failures++;
            $display("FAIL backpressure_done: got %0d required 199", done_cyc);
        end
    endtask

    task automatic test_random();
        logic [7:0] t;
        for (int it = 0; it < 4; it++) begin
            t = 8'($urandom);
            for (int w = 0; w < 64; w++)
                for (int l = 0; l < 4; l++)
                    mem_a[w][l*8 +: 8] = ($urandom % 5 == 0) ? t : 8'($urandom);
            run_a("random", t, it == 0 ? 0 : 1);
        end
    endtask

    task automatic test_abort();
        bit found = 0;
        bit activity = 0;
        fill_a(32'hFFFF_FFFF);
        mem_a[5] = 32'h0505_FFFF;
        a_tick = 8'h05;
        a_start = 1'b1;
        @(posedge CLK); #1;
        a_start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (a_addr == 6'd20) begin found = 1; break; end
            @(posedge CLK); #1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL abort_reach: word 20 not reached within 200 cycles");
        end
        a_next = 1'b1;
        #1;
        checks++;
        if (a_ovr !== 1'b1 || a_wen !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse: overrun=%b w_en=%b required 1 0", a_ovr, a_wen);
        end
        @(posedge CLK); #1;
        a_next = 1'b0;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_ovr !== 1'b0 || a_done !== 1'b0 || a_cnt !== 9'd2) begin
            failures++;
            $display("FAIL abort_idle: busy=%b ovr=%b done=%b cnt=%0d required 0 0 0 2",
                     a_busy, a_ovr, a_done, a_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (a_rd_en || a_wen || a_busy || a_ovr) activity = 1;
        end
        checks++;
        if (activity) begin
            failures++;
            $display("FAIL abort_quiet: activity=1 required 0 after abort");
        end
    endtask

    task automatic test_reset_mid();
        fill_a(32'hFFFF_FFFF);
        mem_a[10] = 32'h0505_0505;
        a_tick = 8'h05;
        a_full = 1'b1;
        a_start = 1'b1;
        @(posedge CLK); #1;
        a_start = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        checks++;
        if (a_busy !== 1'b1 || a_addr !== 6'd10 || a_wen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stall: busy=%b addr=%0d wen=%b required 1 10 0", a_busy, a_addr, a_wen);
        end
        RSTN = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({a_busy, a_done, a_ovr, a_wen, a_rd_en} !== 5'b0 || a_cnt !== 9'd0 || a_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_mid_values: busy=%b done=%b ovr=%b wen=%b rd=%b cnt=%0d addr=%0d required all 0",
                     a_busy, a_done, a_ovr, a_wen, a_rd_en, a_cnt, a_addr);
        end
        RSTN = 1'b1;
        a_full = 1'b0;
        @(posedge CLK); #1;
        run_a("after_reset", 8'h05, 0);
    endtask

    task automatic test_slow_mem();
        int rd_cyc = -1;
        int bw[$];
        int bc[$];
        int bdone = -1;
        for (int w = 0; w < 16; w++) mem_b[w] = 16'hFFFF;
        mem_b[15] = 16'hA000;
        b_tick = 4'hA;
        b_start = 1'b1;
        @(posedge CLK); #1;
        b_start = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            #1;
            if (b_rd_en && b_addr == 4'd15) rd_cyc = cyc;
            if (b_wen) begin bw.push_back(int'(b_wdata)); bc.push_back(cyc); end
            if (b_done) begin bdone = cyc; break; end
            @(posedge CLK); #1;
        end
        checks++;
        if (bw.size() != 1 || bw[0] != 63) begin
            failures++;
            $display("FAIL slow_writes: got %p required '{63}", bw);
        end
        checks++;
        if (bc.size() != 1 || rd_cyc != 75 || bc[0] != rd_cyc + 4) begin
            failures++;
            $display("FAIL slow_latency: rd cycle %0d write cycles %p required rd 75 write 79", rd_cyc, bc);
        end
        checks++;
        if (bdone != 81 || b_cnt !== 7'd1) begin
            failures++;
            $display("FAIL slow_done: done cycle %0d cnt %0d required 81 1", bdone, b_cnt);
        end
        b_next = 1'b1;
        @(posedge CLK); #1;
        b_next = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0;
        a_start = 0; a_next = 0; a_full = 0; a_tick = '0;
        b_start = 0; b_next = 0; b_full = 0; b_tick = '0;
        fill_a(32'hFFFF_FFFF);
        for (int w = 0; w < 16; w++) mem_b[w] = 16'hFFFF;
        test_reset();
        test_empty();
        test_two_match();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid();
        test_slow_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
